// File: rtl/start_token_fifo.sv
// start_token_fifo: start-token FIFO between a producer dataflow process and
// a downstream PE stage. Storage is a shift-register array addressed by a
// signed pointer (-1 = empty); the head token falls through to if_dout.
// Full/empty flags are plain registers updated from the qualified requests.
// Optional feature macro: START_FIFO_OCC_EN adds the if_num_data_valid
// occupancy output (ptr+1, registered alongside ptr).
module start_token_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
`ifdef START_FIFO_OCC_EN
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
`else
  output logic                  if_empty_n
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_EMPTY   = {(ADDR_WIDTH+1){1'b1}};
  localparam logic [ADDR_WIDTH:0] PTR_ZERO    = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] PTR_PREFULL = (ADDR_WIDTH+1)'(DEPTH - 2);

  logic [DATA_WIDTH-1:0] srl_q [0:DEPTH-1];
  logic [ADDR_WIDTH:0]   ptr_q;
  logic [ADDR_WIDTH:0]   ptr_d;
  logic                  full_n_q;
  logic                  full_n_d;
  logic                  empty_n_q;
  logic                  empty_n_d;
  logic                  push_s;
  logic                  pop_s;

  // Requests only take effect when qualified and the relevant flag allows it.
  always_comb begin
    push_s = if_write & if_write_ce & full_n_q;
    pop_s  = if_read & if_read_ce & empty_n_q;
  end

  // Next pointer and flags; simultaneous push+pop leaves everything unchanged.
  always_comb begin
    ptr_d     = ptr_q;
    full_n_d  = full_n_q;
    empty_n_d = empty_n_q;
    case ({push_s, pop_s})
      2'b10: begin
        ptr_d     = ptr_q + PTR_ONE;
        empty_n_d = 1'b1;
        if (ptr_q == PTR_PREFULL) begin
          full_n_d = 1'b0;
        end else begin
          full_n_d = full_n_q;
        end
      end
      2'b01: begin
        ptr_d    = ptr_q - PTR_ONE;
        full_n_d = 1'b1;
        if (ptr_q == PTR_ZERO) begin
          empty_n_d = 1'b0;
        end else begin
          empty_n_d = empty_n_q;
        end
      end
      default: begin
        ptr_d     = ptr_q;
        full_n_d  = full_n_q;
        empty_n_d = empty_n_q;
      end
    endcase
  end

  // Control registers: pointer and flags, cleared asynchronously on reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q     <= PTR_EMPTY;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
    end
  end

  // Token storage shifts on every accepted push; contents are never reset.
  always_ff @(posedge ap_clk) begin
    if (push_s) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        srl_q[i] <= srl_q[i-1];
      end
      srl_q[0] <= if_din;
    end
  end

  // Oldest token sits at the pointer position; undefined while empty.
  assign if_dout    = srl_q[ptr_q[ADDR_WIDTH-1:0]];
  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;

`ifdef START_FIFO_OCC_EN
  logic [ADDR_WIDTH:0] num_q;
  logic [ADDR_WIDTH:0] num_d;

  // Occupancy tracks the next pointer so it updates in the same cycle as ptr.
  always_comb begin
    num_d = ptr_d + PTR_ONE;
  end

  // Occupancy register, zero out of reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      num_q <= PTR_ZERO;
    end else begin
      num_q <= num_d;
    end
  end

  assign if_num_data_valid = num_q;
`endif

endmodule

// File: tb/tb_start_token_fifo.sv
// Directed testbench for start_token_fifo: a DEPTH=4/DATA_WIDTH=4 instance
// (a_*) and a default DEPTH=2/DATA_WIDTH=1 instance (b_*) share clock/reset.
module tb_start_token_fifo;

  logic       ap_clk;
  logic       ap_rst_n;

  logic       a_write_ce, a_write, a_read_ce, a_read;
  logic [3:0] a_din, a_dout;
  logic       a_full_n, a_empty_n;

  logic       b_write_ce, b_write, b_read_ce, b_read;
  logic [0:0] b_din, b_dout;
  logic       b_full_n, b_empty_n;

`ifdef START_FIFO_OCC_EN
  logic [2:0] a_occ;
  logic [1:0] b_occ;
`endif

  int checks;
  int fails;

  start_token_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .DEPTH(4)) dut_a (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .if_write_ce (a_write_ce),
    .if_write    (a_write),
    .if_din      (a_din),
    .if_full_n   (a_full_n),
    .if_read_ce  (a_read_ce),
    .if_read     (a_read),
    .if_dout     (a_dout),
`ifdef START_FIFO_OCC_EN
    .if_empty_n  (a_empty_n),
    .if_num_data_valid (a_occ)
`else
    .if_empty_n  (a_empty_n)
`endif
  );

  start_token_fifo #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2)) dut_b (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .if_write_ce (b_write_ce),
    .if_write    (b_write),
    .if_din      (b_din),
    .if_full_n   (b_full_n),
    .if_read_ce  (b_read_ce),
    .if_read     (b_read),
    .if_dout     (b_dout),
`ifdef START_FIFO_OCC_EN
    .if_empty_n  (b_empty_n),
    .if_num_data_valid (b_occ)
`else
    .if_empty_n  (b_empty_n)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle_a();
    a_write = 1'b0; a_read = 1'b0; a_write_ce = 1'b1; a_read_ce = 1'b1; a_din = 4'h0;
  endtask

  task automatic idle_b();
    b_write = 1'b0; b_read = 1'b0; b_write_ce = 1'b1; b_read_ce = 1'b1; b_din = 1'b0;
  endtask

  task automatic test_reset();
    idle_a(); idle_b();
    ap_rst_n = 1'b0;
    #12;
    ap_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({a_empty_n, a_full_n} !== 2'b01) begin
      fails++; $display("FAIL reset_a_flags got %b expected %b", {a_empty_n, a_full_n}, 2'b01);
    end
    checks++;
    if ({b_empty_n, b_full_n} !== 2'b01) begin
      fails++; $display("FAIL reset_b_flags got %b expected %b", {b_empty_n, b_full_n}, 2'b01);
    end
`ifdef START_FIFO_OCC_EN
    checks++;
    if (a_occ !== 3'd0) begin
      fails++; $display("FAIL reset_a_occ got %0d expected 0", a_occ);
    end
`endif
    // Pop request on an empty FIFO must be ignored.
    a_read = 1'b1;
    step();
    a_read = 1'b0;
    step();
    checks++;
    if ({a_empty_n, a_full_n} !== 2'b01) begin
      fails++; $display("FAIL empty_pop_flags got %b expected %b", {a_empty_n, a_full_n}, 2'b01);
    end
`ifdef START_FIFO_OCC_EN
    checks++;
    if (a_occ !== 3'd0) begin
      fails++; $display("FAIL empty_pop_occ got %0d expected 0", a_occ);
    end
`endif
  endtask

  task automatic test_depth2();
    b_write = 1'b1; b_din = 1'b1;
    step();
    checks++;
    if ({b_empty_n, b_full_n, b_dout} !== 3'b111) begin
      fails++; $display("FAIL d2_push1 got %b expected %b", {b_empty_n, b_full_n, b_dout}, 3'b111);
    end
    b_din = 1'b0;
    step();
    checks++;
    if ({b_empty_n, b_full_n, b_dout} !== 3'b101) begin
      fails++; $display("FAIL d2_push2_full got %b expected %b", {b_empty_n, b_full_n, b_dout}, 3'b101);
    end
    b_din = 1'b1;
    step();
    checks++;
    if ({b_empty_n, b_full_n, b_dout} !== 3'b101) begin
      fails++; $display("FAIL d2_push3_drop got %b expected %b", {b_empty_n, b_full_n, b_dout}, 3'b101);
    end
    b_write = 1'b0; b_read = 1'b1;
    step();
    checks++;
    if ({b_empty_n, b_full_n, b_dout} !== 3'b110) begin
      fails++; $display("FAIL d2_pop1 got %b expected %b", {b_empty_n, b_full_n, b_dout}, 3'b110);
    end
    step();
    b_read = 1'b0;
    checks++;
    if ({b_empty_n, b_full_n} !== 2'b01) begin
      fails++; $display("FAIL d2_pop2_empty got %b expected %b", {b_empty_n, b_full_n}, 2'b01);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] v;
    a_write = 1'b1; a_din = 4'h3;
    step();
    checks++;
    if ({a_empty_n, a_full_n, a_dout} !== 6'b11_0011) begin
      fails++; $display("FAIL b2b_first got %b expected %b", {a_empty_n, a_full_n, a_dout}, 6'b11_0011);
    end
    a_read = 1'b1; a_din = 4'hA;
    step();
    checks++;
    if ({a_empty_n, a_full_n, a_dout} !== 6'b11_1010) begin
      fails++; $display("FAIL b2b_swap got %b expected %b", {a_empty_n, a_full_n, a_dout}, 6'b11_1010);
    end
    for (int i = 0; i < 10; i++) begin
      v = 4'(i + 5);
      a_din = v;
      step();
      checks++;
      if ({a_empty_n, a_full_n, a_dout} !== {2'b11, v}) begin
        fails++; $display("FAIL b2b_cycle%0d got %b expected %b", i, {a_empty_n, a_full_n, a_dout}, {2'b11, v});
      end
    end
`ifdef START_FIFO_OCC_EN
    checks++;
    if (a_occ !== 3'd1) begin
      fails++; $display("FAIL b2b_occ got %0d expected 1", a_occ);
    end
`endif
    a_write = 1'b0;
    step();
    a_read = 1'b0;
    checks++;
    if ({a_empty_n, a_full_n} !== 2'b01) begin
      fails++; $display("FAIL b2b_drain got %b expected %b", {a_empty_n, a_full_n}, 2'b01);
    end
  endtask

  task automatic test_full();
    a_write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_din = 4'(i);
      step();
      if (i == 3) begin
        checks++;
        if (a_full_n !== 1'b1) begin
          fails++; $display("FAIL full_early got %b expected 1", a_full_n);
        end
      end
    end
    checks++;
    if ({a_empty_n, a_full_n, a_dout} !== 6'b10_0001) begin
      fails++; $display("FAIL full_set got %b expected %b", {a_empty_n, a_full_n, a_dout}, 6'b10_0001);
    end
`ifdef START_FIFO_OCC_EN
    checks++;
    if (a_occ !== 3'd4) begin
      fails++; $display("FAIL full_occ got %0d expected 4", a_occ);
    end
`endif
    a_read = 1'b1; a_din = 4'hF;
    step();
    checks++;
    if ({a_empty_n, a_full_n, a_dout} !== 6'b11_0010) begin
      fails++; $display("FAIL full_rw_pop got %b expected %b", {a_empty_n, a_full_n, a_dout}, 6'b11_0010);
    end
`ifdef START_FIFO_OCC_EN
    checks++;
    if (a_occ !== 3'd3) begin
      fails++; $display("FAIL full_rw_occ got %0d expected 3", a_occ);
    end
`endif
    a_write = 1'b0;
    step();
    checks++;
    if (a_dout !== 4'h3) begin
      fails++; $display("FAIL full_drain3 got %h expected 3", a_dout);
    end
    step();
    checks++;
    if (a_dout !== 4'h4) begin
      fails++; $display("FAIL full_drain4 got %h expected 4", a_dout);
    end
    step();
    a_read = 1'b0;
    checks++;
    if ({a_empty_n, a_full_n} !== 2'b01) begin
      fails++; $display("FAIL full_drain_empty got %b expected %b", {a_empty_n, a_full_n}, 2'b01);
    end
  endtask

  task automatic test_async_reset();
    a_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_din = 4'(i + 7);
      step();
    end
    a_write = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({a_empty_n, a_full_n} !== 2'b01) begin
      fails++; $display("FAIL async_rst_flags got %b expected %b", {a_empty_n, a_full_n}, 2'b01);
    end
`ifdef START_FIFO_OCC_EN
    checks++;
    if (a_occ !== 3'd0) begin
      fails++; $display("FAIL async_rst_occ got %0d expected 0", a_occ);
    end
`endif
    #1;
    ap_rst_n = 1'b1;
    a_write = 1'b1; a_din = 4'h5;
    step();
    a_write = 1'b0;
    checks++;
    if ({a_empty_n, a_full_n, a_dout} !== 6'b11_0101) begin
      fails++; $display("FAIL async_rst_push got %b expected %b", {a_empty_n, a_full_n, a_dout}, 6'b11_0101);
    end
  endtask

  task automatic test_ce_gating();
    a_write = 1'b1; a_write_ce = 1'b0; a_din = 4'h9;
    step();
    a_write = 1'b0; a_write_ce = 1'b1;
    checks++;
    if ({a_empty_n, a_full_n, a_dout} !== 6'b11_0101) begin
      fails++; $display("FAIL ce_write_gated got %b expected %b", {a_empty_n, a_full_n, a_dout}, 6'b11_0101);
    end
    a_read = 1'b1; a_read_ce = 1'b0;
    step();
    a_read = 1'b0; a_read_ce = 1'b1;
    checks++;
    if ({a_empty_n, a_full_n, a_dout} !== 6'b11_0101) begin
      fails++; $display("FAIL ce_read_gated got %b expected %b", {a_empty_n, a_full_n, a_dout}, 6'b11_0101);
    end
`ifdef START_FIFO_OCC_EN
    checks++;
    if (a_occ !== 3'd1) begin
      fails++; $display("FAIL ce_occ got %0d expected 1", a_occ);
    end
`endif
    a_read = 1'b1;
    step();
    a_read = 1'b0;
    checks++;
    if ({a_empty_n, a_full_n} !== 2'b01) begin
      fails++; $display("FAIL ce_final_pop got %b expected %b", {a_empty_n, a_full_n}, 2'b01);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_depth2();
    test_back_to_back();
    test_full();
    test_async_reset();
    test_ce_gating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t expected completion", $time);
    $fatal(1);
  end

endmodule
